// File: rtl/seq_generator_if.sv
// Bundle of request and serial-output signals for seq_generator.
// The bench or host drives the request side; the generator drives the output side.
interface seq_generator_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  // Handshake: a request transfers on a rising clk edge where start_valid && start_ready.
  // start_ready is high only while the generator is idle. A request made while busy is
  // dropped, not queued. pattern, repeat_n and gap matter only on the transfer edge.
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [1:0]       gap;
  logic             out;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic [1:0]       prs_st;

  modport master (
    output start_valid, pattern, repeat_n, gap,
    input  start_ready, out, out_valid, frame_start, busy, done, prs_st
  );

  modport slave (
    input  start_valid, pattern, repeat_n, gap,
    output start_ready, out, out_valid, frame_start, busy, done, prs_st
  );
endinterface

// File: rtl/seq_generator.sv
// Serial frame generator: sends a captured pattern MSB-first, repeated with idle gaps.
// Define SEQ_GEN_PARITY_EN to append one even-parity bit to every frame.
module seq_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  state_t           state, state_n, eof_state;
  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] pat_q;
  logic [1:0]       gap_q;
  logic [1:0]       gap_cnt;
  logic [CNT_W-1:0] rem;
  logic [BW-1:0]    bit_cnt;
  logic             done_r;
  logic             accept;
  logic             last_bit;
  logic             frame_end;
  logic             more;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q;
`endif

  assign accept   = bus.start_valid && (state == IDLE);
  assign last_bit = (state == SEND) && (bit_cnt == LAST_BIT);
  // rem is never 0 while busy, so anything other than 1 means another frame follows
  assign more     = (rem != CNT_W'(1));

`ifdef SEQ_GEN_PARITY_EN
  assign frame_end = (state == PAR);
`else
  assign frame_end = last_bit;
`endif

  always_comb begin
    eof_state = IDLE;
    if (more) eof_state = (gap_q != 2'd0) ? GAP : SEND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.start_valid) state_n = SEND;
      SEND: begin
        if (last_bit) begin
`ifdef SEQ_GEN_PARITY_EN
          state_n = PAR;
`else
          state_n = eof_state;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR:  state_n = eof_state;
`endif
      GAP:  if (gap_cnt == gap_q - 2'd1) state_n = SEND;
      default: state_n = IDLE;
    endcase
  end

  // Datapath; the end-of-frame reload is last so it overrides the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      done_r  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        shreg   <= bus.pattern;
        pat_q   <= bus.pattern;
        gap_q   <= bus.gap;
        rem     <= (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
        bit_cnt <= '0;
`ifdef SEQ_GEN_PARITY_EN
        par_q   <= ^bus.pattern;
`endif
      end
      if (state == SEND) begin
        shreg   <= shreg << 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end
      if (state == GAP) gap_cnt <= gap_cnt + 2'd1;
      if (frame_end && more) begin
        rem     <= rem - CNT_W'(1);
        shreg   <= pat_q;
        gap_cnt <= '0;
      end
      done_r <= frame_end && !more;
    end
  end

  always_comb begin
    bus.out = 1'b0;
    case (state)
      SEND:    bus.out = shreg[PAT_W-1];
`ifdef SEQ_GEN_PARITY_EN
      PAR:     bus.out = par_q;
`endif
      default: bus.out = 1'b0;
    endcase
    bus.out_valid   = (state == SEND) || (state == PAR);
    bus.frame_start = (state == SEND) && (bit_cnt == '0);
    bus.busy        = (state != IDLE);
    bus.start_ready = (state == IDLE);
    bus.done        = done_r;
    bus.prs_st      = state;
  end

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: table of requests with hand-written cycle traces,
// plus hand sequences for held requests, back-to-back requests and mid-frame reset.
module tb_seq_generator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_generator_if #(.PAT_W(4), .CNT_W(4)) bus ();

  seq_generator #(.PAT_W(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Trace chars, one per cycle after acceptance: H/L = first bit 1/0 (frame_start),
  // 0/1 = data or parity bit, '-' = gap cycle. The done cycle follows the last char.
  typedef struct {
    logic [3:0] pat;
    logic [3:0] rep;
    logic [1:0] gap;
    string      trace;
  } vec_t;

  vec_t       vecs[7];
  string      t1011, t0110;
  int         total = 0;
  int         bad = 0;
  logic [4:0] exp_q[$];

  // {done, busy, frame_start, out_valid, out}
  function automatic logic [4:0] sample();
    return {bus.done, bus.busy, bus.frame_start, bus.out_valid, bus.out};
  endfunction

  function automatic logic [4:0] char_exp(byte c);
    case (c)
      "-":     return 5'b01000;
      "0":     return 5'b01010;
      "1":     return 5'b01011;
      "H":     return 5'b01111;
      "L":     return 5'b01110;
      default: return 5'b11111;
    endcase
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.pattern  = 4'($urandom_range(0, 15));
    bus.repeat_n = 4'($urandom_range(0, 15));
    bus.gap      = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_req(logic [3:0] pat, logic [3:0] rep, logic [1:0] gap, bit hold);
    @(negedge clk);
    bus.pattern     = pat;
    bus.repeat_n    = rep;
    bus.gap         = gap;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start_valid = 1'b0;
    scramble_inputs();
  endtask

  // Checks every cycle from the first frame bit through the done cycle
  task automatic check_trace(string name, string tr, bit drop_at_done);
    logic [4:0] e;
    for (int i = 0; i < tr.len(); i++) exp_q.push_back(char_exp(tr[i]));
    exp_q.push_back(5'b10000);
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s_cyc%0d", name, cyc), sample(), e);
      if (exp_q.size() == 0 && drop_at_done) bus.start_valid = 1'b0;
    end
  endtask

  task automatic check_idle(string name, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_idle%0d", name, i), sample(), 5'b00000);
    end
  endtask

  initial begin
`ifdef SEQ_GEN_PARITY_EN
    vecs[0] = '{pat: 4'b1011, rep: 4'd1, gap: 2'd0, trace: "H0111"};
    vecs[1] = '{pat: 4'b1011, rep: 4'd3, gap: 2'd2, trace: "H0111--H0111--H0111"};
    vecs[2] = '{pat: 4'b1011, rep: 4'd0, gap: 2'd1, trace: "H0111"};
    vecs[3] = '{pat: 4'b1011, rep: 4'd2, gap: 2'd0, trace: "H0111H0111"};
    vecs[4] = '{pat: 4'b0110, rep: 4'd2, gap: 2'd3, trace: "L1100---L1100"};
    vecs[5] = '{pat: 4'b1001, rep: 4'd2, gap: 2'd1, trace: "H0010-H0010"};
    vecs[6] = '{pat: 4'b0000, rep: 4'd1, gap: 2'd3, trace: "L0000"};
    t1011 = "H0111";
    t0110 = "L1100";
`else
    vecs[0] = '{pat: 4'b1011, rep: 4'd1, gap: 2'd0, trace: "H011"};
    vecs[1] = '{pat: 4'b1011, rep: 4'd3, gap: 2'd2, trace: "H011--H011--H011"};
    vecs[2] = '{pat: 4'b1011, rep: 4'd0, gap: 2'd1, trace: "H011"};
    vecs[3] = '{pat: 4'b1011, rep: 4'd2, gap: 2'd0, trace: "H011H011"};
    vecs[4] = '{pat: 4'b0110, rep: 4'd2, gap: 2'd3, trace: "L110---L110"};
    vecs[5] = '{pat: 4'b1001, rep: 4'd2, gap: 2'd1, trace: "H001-H001"};
    vecs[6] = '{pat: 4'b0000, rep: 4'd1, gap: 2'd3, trace: "L000"};
    t1011 = "H011";
    t0110 = "L110";
`endif

    // Clock/reset
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.pattern     = '0;
    bus.repeat_n    = '0;
    bus.gap         = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", sample(), 5'b00000);
    chk("reset_ready_st", {2'b00, bus.start_ready, bus.prs_st}, 5'b00100);
    rst = 1'b0;
    check_idle("post_reset", 2);

    // Table of single requests
    foreach (vecs[i]) begin
      drive_req(vecs[i].pat, vecs[i].rep, vecs[i].gap, 1'b0);
      check_trace($sformatf("vec%0d", i), vecs[i].trace, 1'b0);
      check_idle($sformatf("vec%0d", i), 2);
    end

    // Request held high across the whole frame, dropped in the done cycle
    drive_req(4'b1011, 4'd1, 2'd0, 1'b1);
    check_trace("held", t1011, 1'b1);
    check_idle("held", 3);

    // New request accepted in the done cycle starts the next cycle
    drive_req(4'b1011, 4'd1, 2'd0, 1'b0);
    check_trace("b2b_first", t1011, 1'b0);
    bus.pattern     = 4'b0110;
    bus.repeat_n    = 4'd1;
    bus.gap         = 2'd0;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    scramble_inputs();
    check_trace("b2b_second", t0110, 1'b0);
    check_idle("b2b", 2);

    // Reset during the second bit of a two-frame request
    drive_req(4'b1011, 4'd2, 2'd0, 1'b0);
    @(negedge clk);
    chk("rst_mid_bit1", sample(), 5'b01111);
    @(negedge clk);
    chk("rst_mid_bit2", sample(), 5'b01010);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", sample(), 5'b00000);
    chk("rst_mid_ready_st", {2'b00, bus.start_ready, bus.prs_st}, 5'b00100);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid", 8);

    // Normal operation after the aborted frame
    drive_req(4'b0110, 4'd1, 2'd0, 1'b0);
    check_trace("after_rst", t0110, 1'b0);
    check_idle("after_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
